// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command-side initiator.
// Holds the ALU opcode encodings, operand/result widths, the issue FSM
// state encoding and the packed operation payload carried through the FIFO.
package alu_pkg;

    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned RES_W  = 5;

    localparam logic [OP_W-1:0] ADD           = 2'b00;
    localparam logic [OP_W-1:0] SUB           = 2'b01;
    localparam logic [OP_W-1:0] NOT_A         = 2'b10;
    localparam logic [OP_W-1:0] REDUCTIONOR_B = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Operation payload as presented to the ALU (tag travels alongside).
    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_op_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous show-ahead FIFO for queued ALU commands.
// Ports:
//   clk, reset     clock, asynchronous active-high reset (flushes pointers)
//   push, din      write din when push and not full
//   pop            advance the read pointer when pop and not empty
//   dout           head entry (valid while empty is low)
//   full, empty    occupancy flags, derived from pointers with an extra MSB
module alu_cmd_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally; the MSB distinguishes full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command-side initiator for a registered 4-bit ALU.
// Buffers commands in a FIFO, issues them one at a time, waits out the
// ALU output register, and returns each result with its tag in order.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   cmd_valid/cmd_ready                command handshake (cmd_ready = !full)
//   cmd_opcode, cmd_a, cmd_b, cmd_tag  command payload
//   alu_opcode, alu_a, alu_b           registered operands to the ALU
//   alu_c                              registered ALU result
//   rsp_valid/rsp_ready                response handshake
//   rsp_data, rsp_tag                  captured result and its command tag
//   busy                               FSM not idle or commands queued
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_c,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy
);

    localparam int unsigned ENTRY_W = OP_W + 2 * DATA_W + TAG_W;

    state_t              state;
    state_t              state_next;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_din;
    logic [ENTRY_W-1:0]  fifo_dout;
    alu_op_t             head_op;
    logic [TAG_W-1:0]    head_tag;

    logic [TAG_W-1:0]    pend_tag;
    logic [TAG_W-1:0]    pend_tag_next;
    alu_op_t             alu_op_next;
    logic                rsp_valid_next;
    logic [RES_W-1:0]    rsp_data_next;
    logic [TAG_W-1:0]    rsp_tag_next;

    // Command queue; no pass-through, so a new command always lands here first.
    assign fifo_push = cmd_valid && !fifo_full;
    assign fifo_din  = {cmd_opcode, cmd_a, cmd_b, cmd_tag};
    assign {head_op, head_tag} = fifo_dout;

    alu_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Both decoded purely from flops, so no input-to-output path exists.
    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, FIFO pop and next values of the registered outputs.
    always_comb begin
        state_next     = state;
        fifo_pop       = 1'b0;
        alu_op_next    = {alu_opcode, alu_a, alu_b};
        pend_tag_next  = pend_tag;
        rsp_valid_next = rsp_valid;
        rsp_data_next  = rsp_data;
        rsp_tag_next   = rsp_tag;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    alu_op_next   = head_op;
                    pend_tag_next = head_tag;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                // ALU samples the operands at the end of this cycle.
                state_next = CAPTURE;
            end
            CAPTURE: begin
                rsp_data_next  = alu_c;
                rsp_tag_next   = pend_tag;
                rsp_valid_next = 1'b1;
                state_next     = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        alu_op_next   = head_op;
                        pend_tag_next = head_tag;
                        state_next    = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output and pending-tag registers; alu_* persist until the next issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_tag   <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_tag    <= '0;
        end else begin
            pend_tag   <= pend_tag_next;
            alu_opcode <= alu_op_next.opcode;
            alu_a      <= alu_op_next.a;
            alu_b      <= alu_op_next.b;
            rsp_valid  <= rsp_valid_next;
            rsp_data   <= rsp_data_next;
            rsp_tag    <= rsp_tag_next;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl driving a registered 4-bit ALU.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int unsigned TAG_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_opcode;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [TAG_W-1:0]  cmd_tag;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [RES_W-1:0]  alu_c;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_tag    (cmd_tag),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    // Registered 4-bit ALU with a 5-bit signed result.
    always_ff @(posedge clk) begin
        case (alu_opcode)
            ADD:     alu_c <= {alu_a[3], alu_a} + {alu_b[3], alu_b};
            SUB:     alu_c <= {alu_a[3], alu_a} - {alu_b[3], alu_b};
            NOT_A:   alu_c <= {~alu_a[3], ~alu_a};
            default: alu_c <= {4'b0000, |alu_b};
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command and hold it until the handshake edge has passed.
    task automatic push(input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [1:0] tag);
        int w;
        w = 0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_tag    = tag;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0;
        cmd_b = '0; cmd_tag = '0; rsp_ready = 1'b0;
        tick(); tick();
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset cmd_ready got %b want 1", cmd_ready); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid got %b want 0", rsp_valid); else passed++;
        checks++; if (rsp_data !== 5'd0) $display("FAIL reset rsp_data got %b want 00000", rsp_data); else passed++;
        checks++; if (rsp_tag !== 2'd0) $display("FAIL reset rsp_tag got %0d want 0", rsp_tag); else passed++;
        checks++; if ({alu_opcode, alu_a, alu_b} !== 10'd0) $display("FAIL reset alu_ops got %h want 0", {alu_opcode, alu_a, alu_b}); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        int lat;
        rsp_ready = 1'b1;
        push(ADD, 4'd7, 4'd1, 2'd1);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 4) $display("FAIL latency cycles got %0d want 4", lat); else passed++;
        checks++; if (rsp_data !== 5'b01000) $display("FAIL latency rsp_data got %b want 01000", rsp_data); else passed++;
        checks++; if (rsp_tag !== 2'd1) $display("FAIL latency rsp_tag got %0d want 1", rsp_tag); else passed++;
        tick();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL latency rsp_valid_after got %b want 0", rsp_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL latency busy_after got %b want 0", busy); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_d [4];
        logic [4:0] d [4];
        logic [1:0] g [4];
        int         ts [4];
        int         n;
        int         t;
        exp_d[0] = 5'b10001; exp_d[1] = 5'b11010; exp_d[2] = 5'b00000; exp_d[3] = 5'b00001;
        rsp_ready = 1'b1;
        push(SUB, 4'b1000, 4'b0111, 2'd0);
        push(NOT_A, 4'b0101, 4'b0000, 2'd1);
        push(REDUCTIONOR_B, 4'b0000, 4'b0000, 2'd2);
        push(REDUCTIONOR_B, 4'b0000, 4'b1000, 2'd3);
        n = 0; t = 0;
        while (n < 4 && t < 60) begin
            if (rsp_valid) begin d[n] = rsp_data; g[n] = rsp_tag; ts[n] = t; n++; end
            tick();
            t++;
        end
        checks++; if (n !== 4) $display("FAIL b2b count got %0d want 4", n); else passed++;
        for (int i = 0; i < n; i++) begin
            checks++; if (d[i] !== exp_d[i]) $display("FAIL b2b data[%0d] got %b want %b", i, d[i], exp_d[i]); else passed++;
            checks++; if (g[i] !== 2'(i)) $display("FAIL b2b tag[%0d] got %0d want %0d", i, g[i], i); else passed++;
            if (i > 0) begin
                checks++; if (ts[i] - ts[i-1] !== 3) $display("FAIL b2b interval[%0d] got %0d want 3", i, ts[i] - ts[i-1]); else passed++;
            end
        end
    endtask

    task automatic test_full();
        logic [4:0] d [5];
        logic [1:0] g [5];
        int         n;
        int         t;
        int         bad;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(ADD, 4'(i + 1), 4'd1, 2'(i));
        checks++; if (cmd_ready !== 1'b0) $display("FAIL full cmd_ready got %b want 0", cmd_ready); else passed++;
        // A command offered while full must be refused, not overwritten.
        bad = 0;
        cmd_valid = 1'b1; cmd_opcode = SUB; cmd_a = 4'd0; cmd_b = 4'd0; cmd_tag = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cmd_ready !== 1'b0) bad++;
        end
        cmd_valid = 1'b0;
        checks++; if (bad !== 0) $display("FAIL full ready_while_full got %0d want 0 bad cycles", bad); else passed++;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL full hold_valid got %b want 1", rsp_valid); else passed++;
        rsp_ready = 1'b1;
        n = 0; t = 0;
        while (n < 5 && t < 80) begin
            if (rsp_valid) begin d[n] = rsp_data; g[n] = rsp_tag; n++; end
            tick();
            t++;
        end
        checks++; if (n !== 5) $display("FAIL full count got %0d want 5", n); else passed++;
        for (int i = 0; i < n; i++) begin
            checks++; if (d[i] !== 5'(i + 2) || g[i] !== 2'(i)) $display("FAIL full rsp[%0d] got %0d/%0d want %0d/%0d", i, d[i], g[i], i + 2, i % 4); else passed++;
        end
        tick(); tick(); tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL full drained got v%b b%b r%b want v0 b0 r1", rsp_valid, busy, cmd_ready); else passed++;
    endtask

    task automatic test_hold_stable();
        int t;
        int bad;
        rsp_ready = 1'b0;
        push(NOT_A, 4'b0000, 4'b0000, 2'd2);
        t = 0;
        while (!rsp_valid && t < 20) begin tick(); t++; end
        checks++; if (rsp_valid !== 1'b1) $display("FAIL hold rsp_valid got %b want 1", rsp_valid); else passed++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 5'b11111 || rsp_tag !== 2'd2) bad++;
            tick();
        end
        checks++; if (bad !== 0) $display("FAIL hold stable got %0d want 0 unstable cycles", bad); else passed++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL hold released got %b want 0", rsp_valid); else passed++;
        tick(); tick(); tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL hold single got v%b b%b want v0 b0", rsp_valid, busy); else passed++;
    endtask

    task automatic test_push_pop_same();
        logic [4:0] d [5];
        logic [1:0] g [5];
        int         n;
        int         t;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(ADD, 4'(i), 4'd3, 2'(i));
        t = 0;
        while (!rsp_valid && t < 20) begin tick(); t++; end
        checks++; if (rsp_data !== 5'd3 || rsp_tag !== 2'd0) $display("FAIL pp first got %0d/%0d want 3/0", rsp_data, rsp_tag); else passed++;
        // Push c3 on the same edge that HOLD pops c1: occupancy stays at 2.
        cmd_valid = 1'b1; cmd_opcode = ADD; cmd_a = 4'd3; cmd_b = 4'd3; cmd_tag = 2'd3;
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL pp ready_at2 got %b want 1", cmd_ready); else passed++;
        push(ADD, 4'd4, 4'd3, 2'd0);
        checks++; if (cmd_ready !== 1'b1) $display("FAIL pp ready_at3 got %b want 1", cmd_ready); else passed++;
        push(ADD, 4'd5, 4'd3, 2'd1);
        checks++; if (cmd_ready !== 1'b0) $display("FAIL pp ready_at4 got %b want 0", cmd_ready); else passed++;
        rsp_ready = 1'b1;
        n = 0; t = 0;
        while (n < 5 && t < 80) begin
            if (rsp_valid) begin d[n] = rsp_data; g[n] = rsp_tag; n++; end
            tick();
            t++;
        end
        checks++; if (n !== 5) $display("FAIL pp count got %0d want 5", n); else passed++;
        for (int i = 0; i < n; i++) begin
            checks++; if (d[i] !== 5'(i + 4) || g[i] !== 2'(i + 1)) $display("FAIL pp rsp[%0d] got %0d/%0d want %0d/%0d", i, d[i], g[i], i + 4, (i + 1) % 4); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int stale;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(ADD, 4'(i), 4'd1, 2'(i + 1));
        // c0 is now in CAPTURE with c1 and c2 queued.
        checks++; if (busy !== 1'b1) $display("FAIL rmid busy_before got %b want 1", busy); else passed++;
        reset = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 5'd0 || rsp_tag !== 2'd0) $display("FAIL rmid rsp got v%b d%b t%0d want all 0", rsp_valid, rsp_data, rsp_tag); else passed++;
        checks++; if ({alu_opcode, alu_a, alu_b} !== 10'd0) $display("FAIL rmid alu_ops got %h want 0", {alu_opcode, alu_a, alu_b}); else passed++;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL rmid flags got b%b r%b want b0 r1", busy, cmd_ready); else passed++;
        reset = 1'b0;
        rsp_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) stale++;
        end
        checks++; if (stale !== 0) $display("FAIL rmid stale got %0d want 0 active cycles", stale); else passed++;
        push(ADD, 4'd3, 4'b1100, 2'd1);
        t = 0;
        while (!rsp_valid && t < 20) begin tick(); t++; end
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 5'b11111 || rsp_tag !== 2'd1) $display("FAIL rmid recover got v%b d%b t%0d want v1 d11111 t1", rsp_valid, rsp_data, rsp_tag); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_full();
        test_hold_stable();
        test_push_pop_same();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Command-side initiator for the registered 4-bit ALU.
- Accepts operation commands (opcode, A, B, tag) over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU, waits out the ALU's one-cycle output register, then captures C.
- Returns the result with its tag over a valid/ready response interface.
- Sits between the testbench or CPU-side command source and the ALU instance.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TAG_W, 2, width of the command tag returned with each result.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_opcode  in  2  00 ADD, 01 SUB, 10 NOT_A, 11 REDUCTIONOR_B.
- cmd_a  in  4  operand A, signed 2's complement.
- cmd_b  in  4  operand B, signed 2's complement.
- cmd_tag  in  TAG_W  caller tag, returned unchanged.
- alu_opcode  out  2  registered; to ALU Opcode.
- alu_a  out  4  registered; to ALU A.
- alu_b  out  4  registered; to ALU B.
- alu_c  in  5  ALU registered result C.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  5  captured result, signed.
- rsp_tag  out  TAG_W  tag of the command that produced rsp_data.
- busy  out  1  high when state != IDLE or FIFO non-empty.

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_tag=0, alu_opcode/alu_a/alu_b=0, busy=0, FIFO empty, state IDLE.
- Push: cmd_valid && cmd_ready at a rising edge writes {opcode,a,b,tag} at the write pointer. Pointers wrap modulo DEPTH. Full/empty use an extra pointer MSB.
- Push while full: cmd_ready=0, so the handshake does not occur, the command is not written and nothing is dropped. No same-cycle pass-through.
- Push and pop in the same cycle are both allowed; the occupancy count is unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, load alu_opcode/a/b and the pending tag, go to ISSUE.
  - ISSUE: operands are stable on alu_*; the ALU registers C at the end of this cycle; go to CAPTURE.
  - CAPTURE: latch alu_c into rsp_data and the pending tag into rsp_tag; set rsp_valid; go to HOLD.
  - HOLD: rsp_valid=1 and rsp_data/rsp_tag held stable until rsp_ready=1.
- HOLD exits on rsp_ready=1:
  - FIFO non-empty: pop and load operands, go to ISSUE, rsp_valid low next cycle.
  - FIFO empty: go to IDLE.
- Latency into an idle block with an empty FIFO: command accepted in cycle 0 → rsp_valid high in cycle 4.
- Throughput: one result per 3 cycles with rsp_ready held high.
- alu_* keep their last issued values outside ISSUE; they are never cleared except by reset.
- Width: rsp_data is the unmodified 5-bit alu_c; no saturation or extension is performed.
- Reset mid-operation, including HOLD: the FIFO is flushed, the in-flight command is discarded and the next cycle is IDLE with all outputs at reset values.
- rsp_ready when rsp_valid=0 is ignored.
- Commands are issued strictly in FIFO order; tags return in the same order.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams ADD/SUB/NOT_A/REDUCTIONOR_B;
  - widths DATA_W=4 and RES_W=5;
  - state encoding IDLE/ISSUE/CAPTURE/HOLD (2-bit).
- Sub-module alu_cmd_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/dout. Entry width = 2+4+4+TAG_W.
- Top level: FSM plus response registers. The bench instantiates it with the ALU.

Test Plan:
- Reset, then ADD A=7 B=1 tag=1 with rsp_ready=1 → rsp_valid rises 4 cycles after accept; rsp_data=5'b01000 (+8), rsp_tag=1.
- SUB A=-8 B=7, then NOT_A A=4'b0101, then REDUCTIONOR_B B=0 and B=4'b1000, tags 0..3, pushed back-to-back → results in order: -15 (5'b10001), -6 (5'b11010), 0, 1; one result per 3 cycles.
- rsp_ready=0, push 5 commands with DEPTH=4 → the first is issued and held in HOLD; the next 4 fill the FIFO; cmd_ready=0 afterwards; no command lost once rsp_ready is released.
- Hold rsp_ready=0 for 10 cycles in HOLD → rsp_valid, rsp_data and rsp_tag constant throughout; a single handshake completes.
- Push and pop in the same cycle with the FIFO at 2 entries → occupancy stays 2 and order is preserved.
- Assert reset during CAPTURE with 2 commands queued → all outputs are 0 next cycle, busy=0, and no stale response appears after reset is released.
